// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  typedef enum logic {CORE = 1'b0, LOADER = 1'b1} req_id_t;
  localparam int WORD_BYTES = 4;
  localparam int CORE_IDX   = 0;
  localparam int LOADER_IDX = 1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Core load/store bus and preload stream bundled for the arbiter.
interface dmem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic [DATA_W-1:0] c_rdata;
  logic              c_rvalid;
  logic              l_start;
  logic [ADDR_W-1:0] l_base;
  logic [LEN_W-1:0]  l_len;
  logic [DATA_W-1:0] l_data;
  logic              l_valid;
  logic              l_ready;
  logic              l_busy;
  logic              l_done;

  modport master (
    output c_req, c_we, c_addr, c_wdata, l_start, l_base, l_len, l_data, l_valid,
    input  c_gnt, c_rdata, c_rvalid, l_ready, l_busy, l_done
  );
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, l_start, l_base, l_len, l_data, l_valid,
    output c_gnt, c_rdata, c_rvalid, l_ready, l_busy, l_done
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last winner remembered.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  req_id_t last_grant;

  always_comb begin
    gnt = req;
    // On contention, the side that did not win last time goes first.
    if (req[CORE_IDX] && req[LOADER_IDX])
      gnt = (last_grant == CORE) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= LOADER;
    else if (gnt[LOADER_IDX])
      last_grant <= LOADER;
    else if (gnt[CORE_IDX])
      last_grant <= CORE;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_memory between core load/store and the burst preload engine.
// Optional DMEM_ARB_BOUNDS_EN blocks misaligned/out-of-range accesses and pulses err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int MEM_WORDS = 1024
)(
  input  logic              clk,
  input  logic              rst,
  dmem_arb_if.slave         bus,
  output logic              err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  cnt;
  logic [1:0]        gnt;
  logic              core_gnt;
  logic              ld_gnt;
  logic              acc_bad;

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .req ({(state == BURST) && bus.l_valid, bus.c_req}),
    .gnt (gnt)
  );

  assign core_gnt    = gnt[CORE_IDX];
  assign ld_gnt      = gnt[LOADER_IDX];
  assign bus.c_gnt   = core_gnt;
  assign bus.l_ready = ld_gnt;
  assign bus.l_busy  = (state != IDLE);

`ifdef DMEM_ARB_BOUNDS_EN
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) ||
           ({1'b0, a} >= (ADDR_W+1)'(MEM_WORDS * WORD_BYTES));
  endfunction

  assign acc_bad = core_gnt ? addr_bad(bus.c_addr) :
                   ld_gnt   ? addr_bad(ptr)        : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else
      err <= acc_bad;
  end
`else
  assign acc_bad = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    if (core_gnt) begin
      mem_A  = bus.c_addr;
      mem_WD = bus.c_wdata;
      mem_WE = bus.c_we && !acc_bad;
    end else if (ld_gnt) begin
      mem_A  = ptr;
      mem_WD = bus.l_data;
      mem_WE = !acc_bad;
    end
  end

  // Burst sequencer; l_done is registered alongside the entry into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      bus.l_done <= 1'b0;
    end else begin
      bus.l_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.l_start) begin
            if (bus.l_len != '0) begin
              ptr   <= bus.l_base;
              cnt   <= bus.l_len;
              state <= BURST;
            end else begin
              state      <= DONE;
              bus.l_done <= 1'b1;
            end
          end
        end
        BURST: begin
          if (ld_gnt) begin
            ptr <= ptr + ADDR_W'(WORD_BYTES);
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              state      <= DONE;
              bus.l_done <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Core read return: data captured at the grant edge, valid the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.c_rdata  <= '0;
      bus.c_rvalid <= 1'b0;
    end else begin
      bus.c_rvalid <= core_gnt && !bus.c_we;
      if (core_gnt && !bus.c_we)
        bus.c_rdata <= acc_bad ? '0 : mem_RD;
    end
  end
endmodule
